afu_output_drain: RTL

Downstream stage of the matrix-transpose `afu_user` block. It pops transposed 512-bit lines from the `afu_user` output FIFO, which has a one-cycle read latency, and buffers them in a small credit-managed skid buffer. It then issues them as addressed write requests on a valid/ready write-back channel. Per job it counts lines, generates consecutive line addresses from a base, and signals completion.

---
 rtl/afu_pkg.sv | 15 +
 rtl/afu_skid_buffer.sv | 63 ++++++
 rtl/afu_output_drain.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/afu_pkg.sv
// afu_pkg: types and constants shared by the afu_user drain path.
package afu_pkg;

  localparam int LINE_WIDTH = 512;

  typedef logic [LINE_WIDTH-1:0] line_t;

  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'd0,
    DRAIN_RUN   = 2'd1,
    DRAIN_FLUSH = 2'd2,
    DRAIN_DONE  = 2'd3
  } drain_state_t;

endpackage

// File: rtl/afu_skid_buffer.sv
// afu_skid_buffer: small register FIFO holding lines between the afu_user
// output FIFO and the write-back channel. Push and pop may happen together.
module afu_skid_buffer
  import afu_pkg::*;
#(
  parameter int WIDTH = LINE_WIDTH,
  parameter int DEPTH = 2,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [OCC_W-1:0] occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [OCC_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != OCC_W'(DEPTH)) || do_pop);

  assign head      = mem[rd_ptr];
  assign occupancy = count;

  // Storage, pointers and occupancy; reset empties the buffer and zeroes the head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + OCC_W'(1);
      end else if (!do_push && do_pop) begin
        count <= count - OCC_W'(1);
      end
    end
  end

endmodule

// File: rtl/afu_output_drain.sv
// afu_output_drain: pops transposed lines from the afu_user output FIFO
// (one-cycle read latency) through a credit-managed skid buffer and issues
// them as addressed write requests, one job at a time.
// Optional feature macro: AFU_DRAIN_PERF_EN adds stall/starve counters.
module afu_output_drain #(
  parameter int DATA_WIDTH  = 16,
  parameter int LINE_WIDTH  = afu_pkg::LINE_WIDTH,
  parameter int ADDR_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int BUF_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] num_lines,
  output logic                   busy,
  output logic                   done,
  input  logic [LINE_WIDTH-1:0]  output_fifo_dout,
  input  logic                   output_fifo_empty,
  output logic                   output_fifo_re,
  output logic                   wr_valid,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [LINE_WIDTH-1:0]  wr_data,
  input  logic                   wr_ready
`ifdef AFU_DRAIN_PERF_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [31:0]            starve_cycles
`endif
);

  import afu_pkg::*;

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);

  if (LINE_WIDTH % DATA_WIDTH != 0) begin : g_bad_line_width
    $error("afu_output_drain: LINE_WIDTH must be a multiple of DATA_WIDTH");
  end
  if (BUF_DEPTH < 2) begin : g_bad_buf_depth
    $error("afu_output_drain: BUF_DEPTH must be at least 2");
  end

  drain_state_t           state;
  drain_state_t           state_next;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [COUNT_WIDTH-1:0] num_q;
  logic [COUNT_WIDTH-1:0] rd_cnt;
  logic [COUNT_WIDTH-1:0] wr_cnt;
  logic [COUNT_WIDTH-1:0] wr_cnt_next;
  logic                   inflight;
  logic                   start_accept;
  logic                   wr_fire;
  logic [OCC_W-1:0]       occupancy;
  logic [OCC_W:0]         credit_used;
  logic [OCC_W:0]         credit_limit;
  logic                   credit_ok;

  afu_skid_buffer #(
    .WIDTH (LINE_WIDTH),
    .DEPTH (BUF_DEPTH),
    .OCC_W (OCC_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (output_fifo_dout),
    .pop       (wr_fire),
    .head      (wr_data),
    .occupancy (occupancy)
  );

  assign wr_valid    = (occupancy != '0);
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_addr     = base_q + ADDR_WIDTH'(wr_cnt);
  assign wr_cnt_next = wr_cnt + COUNT_WIDTH'(wr_fire);

  // A head pop in the same cycle frees a slot before the requested line
  // lands, so it adds one credit; this keeps a full-rate stream going.
  assign credit_used  = {1'b0, occupancy} + {{OCC_W{1'b0}}, inflight};
  assign credit_limit = (OCC_W + 1)'(BUF_DEPTH) + {{OCC_W{1'b0}}, wr_fire};
  assign credit_ok    = credit_used < credit_limit;

  // Job state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= DRAIN_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control outputs; a zero-line job spends one busy cycle
  // in FLUSH, where the write count already matches, before completing.
  always_comb begin
    state_next     = state;
    start_accept   = 1'b0;
    output_fifo_re = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (state)
      DRAIN_IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          state_next   = (num_lines == '0) ? DRAIN_FLUSH : DRAIN_RUN;
        end
      end
      DRAIN_RUN: begin
        busy           = 1'b1;
        output_fifo_re = !output_fifo_empty && (rd_cnt < num_q) && credit_ok;
        if (rd_cnt == num_q) begin
          state_next = DRAIN_FLUSH;
        end
      end
      DRAIN_FLUSH: begin
        busy = 1'b1;
        if (wr_cnt_next == num_q) begin
          state_next = DRAIN_DONE;
        end
      end
      DRAIN_DONE: begin
        done       = 1'b1;
        state_next = DRAIN_IDLE;
      end
      default: begin
        state_next = DRAIN_IDLE;
      end
    endcase
  end

  // Job parameters, read/write line counters and the in-flight read flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q   <= '0;
      num_q    <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= output_fifo_re;
      if (start_accept) begin
        base_q <= base_addr;
        num_q  <= num_lines;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        if (output_fifo_re) begin
          rd_cnt <= rd_cnt + COUNT_WIDTH'(1);
        end
        wr_cnt <= wr_cnt_next;
      end
    end
  end

`ifdef AFU_DRAIN_PERF_EN
  logic starving;

  assign starving = (state == DRAIN_RUN) && (occupancy == '0) && !inflight
                    && output_fifo_empty;

  // Saturating counters of back-pressure stalls and upstream starvation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles  <= '0;
      starve_cycles <= '0;
    end else if (start_accept) begin
      stall_cycles  <= '0;
      starve_cycles <= '0;
    end else begin
      if (wr_valid && !wr_ready && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (starving && (starve_cycles != '1)) begin
        starve_cycles <= starve_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
